// File: rtl/radix_divider_pkg.sv
// Shared widths, FSM encoding and counter sizing for the radix divider.
// No logic of its own; no latency.
// No flow control; constants and a helper function only.
package radix_divider_pkg;

  localparam int DIVIDEND_W_DFLT = 8;
  localparam int DIVISOR_W_DFLT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bits needed to count down from w-1 to 0 (at least one bit).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DFLT = cnt_w(DIVIDEND_W_DFLT);

endpackage

// File: rtl/radix_divider_if.sv
// Request/result bundle between a divider client and the divider.
// No logic of its own; no latency.
// No backpressure: start is ignored while busy, done is a single pulse.
interface radix_divider_if #(
  parameter int DIVIDEND_W = radix_divider_pkg::DIVIDEND_W_DFLT,
  parameter int DIVISOR_W  = radix_divider_pkg::DIVISOR_W_DFLT
) ();

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/radix_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle by the owning FSM.
module div_step #(
  parameter int DIVISOR_W = radix_divider_pkg::DIVISOR_W_DFLT
) (
  input  logic [DIVISOR_W:0]   prem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  // The difference is only used when shifted >= divisor, so the narrower subtract cannot wrap.
  always_comb begin
    shifted  = {prem_in, bit_in};
    diff     = shifted[DIVISOR_W:0] - {1'b0, divisor};
    q_bit    = (shifted >= {2'b00, divisor});
    prem_out = q_bit ? diff : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/radix_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// start accepted at edge k -> done pulse in the cycle after edge k+DIVIDEND_W.
// No queueing: start is ignored unless idle; results hold until the next accepted start.
module radix_divider
  import radix_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DFLT,
  parameter int DIVISOR_W  = DIVISOR_W_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  radix_divider_if.slave bus
);

  localparam int CNT_W = cnt_w(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // remaining dividend bits, quotient bits enter at LSB
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_prem;
  logic                  step_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .prem_in (prem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .prem_out(step_prem),
    .q_bit   (step_bit)
  );

  // Next-state, iteration and result update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          prem_d  = '0;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      RUN: begin
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], step_bit};
        prem_d = step_prem;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          // A zero divisor still runs the full schedule so latency never depends on data.
          if (dsr_q == '0) begin
            quo_d = '1;
            rem_d = '0;
            dbz_d = 1'b1;
          end else begin
            quo_d = {dvd_q[DIVIDEND_W-2:0], step_bit};
            rem_d = step_prem[DIVISOR_W-1:0];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

endmodule

// File: doc/radix_divider.md
RADIX_DIVIDER -- requirements
Module: radix_divider

Interface
REQ-001 Parameter: DIVIDEND_W, 8, dividend and quotient width.
REQ-002 Parameter: DIVISOR_W, 4, divisor and remainder width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request to begin a division; sampled on clk rising edge.
REQ-006 Port: dividend  input  DIVIDEND_W  unsigned dividend; captured when start is accepted.
REQ-007 Port: divisor  input  DIVISOR_W  unsigned divisor; captured when start is accepted.
REQ-008 Port: quotient  output  DIVIDEND_W  unsigned quotient, registered.
REQ-009 Port: remainder  output  DIVISOR_W  unsigned remainder, registered.
REQ-010 Port: busy  output  1  high while an operation is in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking valid quotient/remainder.
REQ-012 Port: div_by_zero  output  1  high with done when the captured divisor was zero; held until next accepted start.

Function
REQ-013 Algorithm SHALL be restoring division, one quotient bit per clock, MSB first, using a (DIVISOR_W+1)-bit partial remainder.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE -> RUN when start=1: operands latched, partial remainder cleared, iteration counter = DIVIDEND_W-1, busy=1 from the next cycle.
REQ-016 RUN: each cycle shift partial remainder left with next dividend bit, subtract divisor, keep result and set quotient bit if non-negative, else restore and clear bit; counter decrements.
REQ-017 RUN -> DONE after exactly DIVIDEND_W iterations; quotient/remainder registers updated at that edge.
REQ-018 DONE: done=1, busy=0 for exactly one cycle; next state IDLE.
REQ-019 Latency: start sampled at edge k -> done high in the cycle after edge k+DIVIDEND_W (9th cycle after start for defaults).
REQ-020 quotient, remainder, div_by_zero SHALL hold their values from DONE until the edge following the next accepted start, then clear to 0.
REQ-021 start while in RUN or DONE SHALL be ignored; no second operation is queued.
REQ-022 Operand inputs SHALL be don't-care except on the accept edge.
REQ-023 divisor=0: full latency still taken; result forced to quotient=all ones, remainder=0, div_by_zero=1.
REQ-024 dividend < divisor: quotient=0, remainder=dividend.

Reset
REQ-025 rst low SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0, irrespective of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse after release.
REQ-027 start SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-028 Shared package SHALL hold DIVIDEND_W/DIVISOR_W defaults, FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), counter width.
REQ-029 One combinational sub-module div_step SHALL perform shift-compare-subtract-restore for one bit; FSM, counter and output registers stay in radix_divider.

Verification
REQ-030 dividend=200, divisor=7, start one cycle -> done on 9th cycle, quotient=28, remainder=4, div_by_zero=0.
REQ-031 255/15 -> quotient=17, remainder=0; 255/1 -> quotient=255, remainder=0.
REQ-032 13/14 -> quotient=0, remainder=13; busy high exactly 8 cycles.
REQ-033 divisor=0, dividend=0x5A -> quotient=0xFF, remainder=0, div_by_zero=1 with done.
REQ-034 start 100/3 then start 50/5 asserted during RUN -> single done, quotient=33, remainder=1; second request dropped.
REQ-035 rst low at RUN cycle 4 -> all outputs 0 immediately, no done afterward; post-reset 9/2 gives quotient=4, remainder=1.
